mem_port_arbiter: RTL

- Shares one single-ported, Avalon-style memory between the processor's instruction-fetch port (read-only) and data port (read/write).
- Grants one transaction at a time and holds the losing requester with waitrequest. Read data is routed back to the owner.
- D-port has priority because it carries the older instruction in the Memory stage. A starvation counter bounds how long I-port can be locked out.

---
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one Avalon-style memory between the fetch and data ports.
// The data port wins ties; a starvation counter eventually forces a fetch grant.
module mem_port_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 IRead,
    input  logic [WORD_SIZE-1:0] IAddr,
    output logic                 IWaitreq,
    output logic [WORD_SIZE-1:0] IRdata,
    output logic                 IRvalid,
    input  logic                 DRead,
    input  logic                 DWrite,
    input  logic [WORD_SIZE-1:0] DAddr,
    input  logic [WORD_SIZE-1:0] DWdata,
    output logic                 DWaitreq,
    output logic [WORD_SIZE-1:0] DRdata,
    output logic                 DRvalid,
    output logic [WORD_SIZE-1:0] MemAddr,
    output logic [WORD_SIZE-1:0] MemWdata,
    output logic                 MemRead,
    output logic                 MemWrite,
    input  logic                 MemWaitreq,
    input  logic [WORD_SIZE-1:0] MemRdata,
    input  logic                 MemRvalid
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] GNT_I = 3'd1;
    localparam logic [2:0] GNT_D = 3'd2;
    localparam logic [2:0] RD_I  = 3'd3;
    localparam logic [2:0] RD_D  = 3'd4;

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] starve;
    logic [CW-1:0] starve_nxt;
    logic          d_req;
    logic          i_acc;
    logic          d_acc;

    assign d_req = DRead | DWrite;
    assign i_acc = (state == GNT_I) & ~MemWaitreq;
    assign d_acc = (state == GNT_D) & ~MemWaitreq;

    assign IWaitreq = IRead & ~i_acc;
    assign DWaitreq = d_req & ~d_acc;

    // Read data is forwarded straight through to whichever port owns the read.
    assign IRvalid = (state == RD_I) & MemRvalid;
    assign DRvalid = (state == RD_D) & MemRvalid;
    assign IRdata  = IRvalid ? MemRdata : '0;
    assign DRdata  = DRvalid ? MemRdata : '0;

    // Next-state and starvation bookkeeping; requests are only arbitrated in IDLE.
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve;
        case (state)
            IDLE: begin
                if (d_req && (starve < LIMIT || !IRead)) begin
                    state_nxt = GNT_D;
                    if (IRead && starve < LIMIT)
                        starve_nxt = starve + CW'(1);
                end else if (IRead) begin
                    state_nxt  = GNT_I;
                    starve_nxt = '0;
                end
            end
            GNT_I: begin
                if (!IRead)
                    state_nxt = IDLE;
                else if (!MemWaitreq)
                    state_nxt = RD_I;
            end
            GNT_D: begin
                if (!d_req)
                    state_nxt = IDLE;
                else if (!MemWaitreq)
                    state_nxt = DWrite ? IDLE : RD_D;
            end
            RD_I, RD_D: begin
                if (MemRvalid)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory command mux: only the granted port drives the bus, writes win over reads.
    always_comb begin
        MemAddr  = '0;
        MemWdata = '0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        if (state == GNT_I) begin
            MemAddr = IAddr;
            MemRead = IRead;
        end else if (state == GNT_D) begin
            MemAddr  = DAddr;
            MemWdata = DWdata;
            MemWrite = DWrite;
            MemRead  = DRead & ~DWrite;
        end
    end

    // State registers; reset abandons any outstanding transaction.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state  <= IDLE;
            starve <= '0;
        end else begin
            state  <= state_nxt;
            starve <= starve_nxt;
        end
    end

endmodule
